// File: rtl/trd_sched.sv
// Per-thread PC register file and round-robin scheduler for the 8-thread barrel front end.
// Tracks OFF/RDY/WAIT per thread and issues one runnable thread per cycle with a 1-cycle latency.
module trd_sched #(
  parameter logic [31:0] BOOT_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] nxt_pc_0,
  input  logic [31:0] nxt_pc_1,
  input  logic [31:0] nxt_pc_2,
  input  logic [31:0] nxt_pc_3,
  input  logic [31:0] nxt_pc_4,
  input  logic [31:0] nxt_pc_5,
  input  logic [31:0] nxt_pc_6,
  input  logic [31:0] nxt_pc_7,
  input  logic [7:0]  pc_wr,
  input  logic        i_miss,
  input  logic [2:0]  i_miss_trd,
  input  logic        d_miss,
  input  logic [2:0]  d_miss_trd,
  input  logic [7:0]  miss_done,
  input  logic        spawn_vld,
  input  logic [2:0]  spawn_trd,
  input  logic [31:0] spawn_pc,
  input  logic        kill_vld,
  input  logic [2:0]  kill_trd,
  input  logic        fetch_stall,
  output logic        issue_vld,
  output logic [2:0]  cur_trd,
  output logic [31:0] cur_pc,
  output logic [7:0]  run_mask,
  output logic [7:0]  wait_mask
);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_RDY  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]  r_state [8];
  logic [31:0] r_pc    [8];
  logic [2:0]  r_last;
  logic        r_issue_vld;
  logic [2:0]  r_cur_trd;
  logic [31:0] r_cur_pc;
  logic [7:0]  r_run_mask;
  logic [7:0]  r_wait_mask;

  logic [31:0] w_nxt_pc    [8];
  logic [1:0]  w_state_nxt [8];
  logic [7:0]  w_kill;
  logic [7:0]  w_miss;
  logic [7:0]  w_spawn;
  logic [7:0]  w_elig;
  logic [2:0]  w_idx;
  logic [2:0]  w_sel;
  logic        w_any;
  logic [31:0] w_sel_pc;

  assign w_nxt_pc[0] = nxt_pc_0;
  assign w_nxt_pc[1] = nxt_pc_1;
  assign w_nxt_pc[2] = nxt_pc_2;
  assign w_nxt_pc[3] = nxt_pc_3;
  assign w_nxt_pc[4] = nxt_pc_4;
  assign w_nxt_pc[5] = nxt_pc_5;
  assign w_nxt_pc[6] = nxt_pc_6;
  assign w_nxt_pc[7] = nxt_pc_7;

  // Per-thread events and next state; kill beats miss beats miss_done beats spawn.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_kill[i]  = kill_vld && (kill_trd == 3'(i));
      w_miss[i]  = (i_miss && (i_miss_trd == 3'(i))) || (d_miss && (d_miss_trd == 3'(i)));
      w_spawn[i] = spawn_vld && (spawn_trd == 3'(i)) && (r_state[i] == ST_OFF) && !w_kill[i];
      w_elig[i]  = ((r_state[i] == ST_RDY) || ((r_state[i] == ST_WAIT) && miss_done[i]))
                   && !w_kill[i] && !w_miss[i];
      w_state_nxt[i] = r_state[i];
      if (w_kill[i])
        w_state_nxt[i] = ST_OFF;
      else if (w_miss[i] && (r_state[i] != ST_OFF))
        w_state_nxt[i] = ST_WAIT;
      else if (miss_done[i] && (r_state[i] == ST_WAIT))
        w_state_nxt[i] = ST_RDY;
      else if (w_spawn[i])
        w_state_nxt[i] = ST_RDY;
    end
  end

  // Scan last+1 .. last+8 so the previous winner is picked only when alone.
  always_comb begin
    w_sel = r_last;
    w_any = 1'b0;
    w_idx = r_last;
    for (int k = 1; k <= 8; k++) begin
      w_idx = r_last + 3'(k);
      if (!w_any && w_elig[w_idx]) begin
        w_sel = w_idx;
        w_any = 1'b1;
      end
    end
    w_sel_pc = pc_wr[w_sel] ? w_nxt_pc[w_sel] : r_pc[w_sel];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_pc[i]    <= BOOT_PC;
        r_state[i] <= (i == 0) ? ST_RDY : ST_OFF;
      end
      r_last      <= 3'd7;
      r_issue_vld <= 1'b0;
      r_cur_trd   <= 3'd0;
      r_cur_pc    <= BOOT_PC;
      r_run_mask  <= 8'h01;
      r_wait_mask <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) begin
        r_state[i]     <= w_state_nxt[i];
        r_run_mask[i]  <= (w_state_nxt[i] == ST_RDY);
        r_wait_mask[i] <= (w_state_nxt[i] == ST_WAIT);
        if (w_spawn[i])
          r_pc[i] <= spawn_pc;
        else if (pc_wr[i])
          r_pc[i] <= w_nxt_pc[i];
      end
      if (!fetch_stall) begin
        if (w_any) begin
          r_issue_vld <= 1'b1;
          r_cur_trd   <= w_sel;
          r_cur_pc    <= w_sel_pc;
          r_last      <= w_sel;
        end else begin
          r_issue_vld <= 1'b0;
        end
      end
    end
  end

  assign issue_vld = r_issue_vld;
  assign cur_trd   = r_cur_trd;
  assign cur_pc    = r_cur_pc;
  assign run_mask  = r_run_mask;
  assign wait_mask = r_wait_mask;

endmodule
